lsu: RTL and testbench

Load/store unit of the hart's memory stage. Consumes the effective address produced by the execute-stage ALU, together with the instruction's compressed `op_ir` and the store operand. Runs one data-cache transaction per memory instruction over a req/ack handshake: lane-aligned store data and byte enables out, extracted and sign/zero-extended load data back. Detects misaligned accesses and reports them as exceptions without touching the cache.

---
 rtl/lsu.sv | 92 +++++++++
 tb/tb_lsu.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// lsu: memory-stage load/store unit with req/ack data-cache handshake and misalignment exceptions.
module lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_valid,
  input  logic [14:0] op_ir,
  input  logic [63:0] addr,
  input  logic [63:0] rs2,
  output logic        dc_req,
  output logic        dc_we,
  output logic [63:0] dc_addr,
  output logic [63:0] dc_wdata,
  output logic [7:0]  dc_be,
  input  logic [63:0] dc_rdata,
  input  logic        dc_ack,
  output logic        lsu_busy,
  output logic        lsu_done,
  output logic [63:0] lsu_rdata,
  output logic        lsu_exc,
  output logic [3:0]  lsu_cause,
  output logic [63:0] lsu_tval
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t r_state, w_next;
  logic [6:0]  w_opc;
  logic [2:0]  w_f3, r_f3;
  logic        w_ld, w_st, w_mis, w_acc, r_st, w_unused;
  logic [63:0] r_addr, r_rs2, w_fld, w_ext;
  logic [7:0]  w_be;
  assign w_opc    = op_ir[6:0];
  assign w_f3     = op_ir[9:7];
  assign w_unused = ^op_ir[14:10];
  assign w_ld     = w_opc == 7'b0000011 && w_f3 != 3'b111;
  assign w_st     = w_opc == 7'b0100011 && !w_f3[2];
  assign w_mis    = w_f3[1:0] == 2'd0 ? 1'b0 :
                    w_f3[1:0] == 2'd1 ? addr[0] :
                    w_f3[1:0] == 2'd2 ? |addr[1:0] : |addr[2:0];
  // DONE is not busy, so a new instruction may be accepted there
  assign w_acc    = lsu_valid && (w_ld || w_st) && r_state != REQ;
  assign w_fld    = dc_rdata >> {r_addr[2:0], 3'b000};
  assign w_ext    = r_st              ? '0 :
                    r_f3 == 3'b000    ? {{56{w_fld[7]}}, w_fld[7:0]} :
                    r_f3 == 3'b001    ? {{48{w_fld[15]}}, w_fld[15:0]} :
                    r_f3 == 3'b010    ? {{32{w_fld[31]}}, w_fld[31:0]} :
                    r_f3 == 3'b100    ? {56'b0, w_fld[7:0]} :
                    r_f3 == 3'b101    ? {48'b0, w_fld[15:0]} :
                    r_f3 == 3'b110    ? {32'b0, w_fld[31:0]} : w_fld;
  assign w_be     = r_f3[1:0] == 2'd0 ? 8'h01 :
                    r_f3[1:0] == 2'd1 ? 8'h03 :
                    r_f3[1:0] == 2'd2 ? 8'h0F : 8'hFF;
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state == REQ ? (dc_ack ? DONE : REQ) : (w_acc && !w_mis ? REQ : IDLE);
  end
  always_comb begin
    dc_req   = r_state == REQ;
    lsu_busy = r_state == REQ;
    lsu_done = r_state == DONE;
    dc_we    = r_state == REQ && r_st;
    dc_addr  = r_state == REQ ? {r_addr[63:3], 3'b000} : '0;
    dc_wdata = r_state == REQ ? r_rs2 << {r_addr[2:0], 3'b000} : '0;
    dc_be    = r_state == REQ ? w_be << r_addr[2:0] : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_rs2     <= '0;
      r_f3      <= '0;
      r_st      <= 1'b0;
      lsu_rdata <= '0;
      lsu_exc   <= 1'b0;
      lsu_cause <= '0;
      lsu_tval  <= '0;
    end else begin
      lsu_exc <= w_acc && w_mis;
      if (w_acc && w_mis) begin
        lsu_cause <= w_st ? 4'd6 : 4'd4;
        lsu_tval  <= addr;
      end
      if (w_acc && !w_mis) begin
        r_addr <= addr;
        r_rs2  <= rs2;
        r_f3   <= w_f3;
        r_st   <= w_st;
      end
      if (r_state == REQ && dc_ack) lsu_rdata <= w_ext;
    end
  end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed stimulus for lsu, checked every cycle against a byte-level behavioural model.
module tb_lsu;
  logic        clk = 0, rst = 1, lsu_valid = 0, dc_ack = 0;
  logic [14:0] op_ir = 0;
  logic [63:0] addr = 0, rs2 = 0, dc_rdata = 0;
  logic        dc_req, dc_we, lsu_busy, lsu_done, lsu_exc;
  logic [63:0] dc_addr, dc_wdata, lsu_rdata, lsu_tval, last_wd;
  logic [7:0]  dc_be;
  logic [3:0]  lsu_cause;
  int total = 0, bad = 0;

  lsu dut (.clk(clk), .rst(rst), .lsu_valid(lsu_valid), .op_ir(op_ir), .addr(addr), .rs2(rs2),
           .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_be(dc_be),
           .dc_rdata(dc_rdata), .dc_ack(dc_ack), .lsu_busy(lsu_busy), .lsu_done(lsu_done),
           .lsu_rdata(lsu_rdata), .lsu_exc(lsu_exc), .lsu_cause(lsu_cause), .lsu_tval(lsu_tval));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic bit is_mem(input logic [14:0] ir);
    return (ir[6:0] == 7'h03 && ir[9:7] != 3'd7) || (ir[6:0] == 7'h23 && ir[9:7] < 3'd4);
  endfunction

  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [63:0] ld_val(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] rd);
    logic [63:0] v = 0;
    int n = nbytes(f3);
    int o = int'(a[2:0]);
    for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(o+i) +: 8];
    if (!f3[2] && n < 8 && v[8*n-1]) for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] exp_be(input logic [2:0] f3, input logic [63:0] a);
    logic [7:0] b = 0;
    for (int i = 0; i < nbytes(f3); i++) b[int'(a[2:0]) + i] = 1'b1;
    return b;
  endfunction

  function automatic logic [63:0] exp_wd(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] d);
    logic [63:0] w = 0;
    for (int i = 0; i < nbytes(f3); i++) w[8*(int'(a[2:0])+i) +: 8] = d[8*i +: 8];
    return w;
  endfunction

  function automatic logic [63:0] lane_mask(input logic [7:0] be);
    logic [63:0] m = 0;
    for (int i = 0; i < 8; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  // Model: one transaction outstanding at most; pulses computed for the following cycle
  bit          m_live, m_busy, m_done, m_exc, m_st;
  logic [63:0] m_addr, m_rs2, m_rdata, m_tval;
  logic [2:0]  m_f3;
  logic [3:0]  m_cause;

  always @(posedge clk) begin
    if (rst) begin
      m_live <= 1; m_busy <= 0; m_done <= 0; m_exc <= 0;
      m_rdata <= 0; m_cause <= 0; m_tval <= 0;
    end else begin
      m_done <= m_busy && dc_ack;
      m_exc  <= 0;
      if (m_busy) begin
        if (dc_ack) begin
          m_busy  <= 0;
          m_rdata <= m_st ? 64'd0 : ld_val(m_f3, m_addr, dc_rdata);
        end
      end else if (lsu_valid && is_mem(op_ir)) begin
        if (addr % 64'(nbytes(op_ir[9:7])) != 0) begin
          m_exc   <= 1;
          m_cause <= op_ir[6:0] == 7'h23 ? 4'd6 : 4'd4;
          m_tval  <= addr;
        end else begin
          m_busy <= 1; m_addr <= addr; m_rs2 <= rs2;
          m_f3 <= op_ir[9:7]; m_st <= op_ir[6:0] == 7'h23;
        end
      end
    end
  end

  always @(negedge clk) if (m_live) begin
    chk("m.req", dc_req, m_busy);
    chk("m.busy", lsu_busy, m_busy);
    chk("m.done", lsu_done, m_done);
    chk("m.exc", lsu_exc, m_exc);
    if (m_busy) begin
      chk("m.we", dc_we, m_st);
      chk("m.addr", dc_addr, m_addr - (m_addr % 8));
      chk("m.be", dc_be, exp_be(m_f3, m_addr));
      if (m_st) chk("m.wdata", dc_wdata & lane_mask(exp_be(m_f3, m_addr)), exp_wd(m_f3, m_addr, m_rs2));
    end
    if (m_done) chk("m.rdata", lsu_rdata, m_rdata);
    if (m_exc) begin
      chk("m.cause", lsu_cause, m_cause);
      chk("m.tval", lsu_tval, m_tval);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_op(input string nm, input logic [6:0] opc, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] d, input logic [63:0] rd, input int k,
                        input logic [63:0] e_addr, input logic [7:0] e_be, input logic e_we,
                        input logic [63:0] e_rd);
    int nreq = 0;
    lsu_valid = 1; op_ir = {5'b0, f3, opc}; addr = a; rs2 = d; dc_rdata = rd;
    tick();
    lsu_valid = 0;
    chk({nm, ".addr"}, dc_addr, e_addr);
    chk({nm, ".be"}, dc_be, e_be);
    chk({nm, ".we"}, dc_we, e_we);
    last_wd = dc_wdata;
    for (int i = 0; i <= k; i++) begin
      nreq += int'(dc_req);
      dc_ack = (i == k);
      tick();
    end
    dc_ack = 0;
    chk({nm, ".reqcyc"}, nreq, k + 1);
    chk({nm, ".done"}, lsu_done, 1);
    chk({nm, ".rdata"}, lsu_rdata, e_rd);
    tick();
    chk({nm, ".done1"}, lsu_done, 0);
  endtask

  task automatic exc_op(input string nm, input logic [6:0] opc, input logic [2:0] f3,
                        input logic [63:0] a, input logic [3:0] e_cause);
    lsu_valid = 1; op_ir = {5'b0, f3, opc}; addr = a;
    tick();
    lsu_valid = 0;
    chk({nm, ".exc"}, lsu_exc, 1);
    chk({nm, ".cause"}, lsu_cause, e_cause);
    chk({nm, ".tval"}, lsu_tval, a);
    chk({nm, ".req"}, dc_req, 0);
    tick();
    chk({nm, ".exc1"}, lsu_exc, 0);
    chk({nm, ".busy1"}, lsu_busy, 0);
  endtask

  initial begin
    int nd = 0;
    rst = 1;
    tick(); tick();
    chk("rst.req", dc_req, 0);     chk("rst.we", dc_we, 0);
    chk("rst.addr", dc_addr, 0);   chk("rst.wdata", dc_wdata, 0);
    chk("rst.be", dc_be, 0);       chk("rst.busy", lsu_busy, 0);
    chk("rst.done", lsu_done, 0);  chk("rst.exc", lsu_exc, 0);
    chk("rst.rdata", lsu_rdata, 0); chk("rst.cause", lsu_cause, 0);
    chk("rst.tval", lsu_tval, 0);
    rst = 0;
    tick();
    mem_op("ld", 7'h03, 3'b011, 64'h1000, 0, 64'h1122334455667788, 0,
           64'h1000, 8'hFF, 0, 64'h1122334455667788);
    mem_op("lb", 7'h03, 3'b000, 64'h2007, 0, 64'h80FF000000000000, 0,
           64'h2000, 8'h80, 0, 64'hFFFFFFFFFFFFFF80);
    mem_op("lbu", 7'h03, 3'b100, 64'h2007, 0, 64'h80FF000000000000, 0,
           64'h2000, 8'h80, 0, 64'h80);
    mem_op("sh", 7'h23, 3'b001, 64'h3002, 64'hABCD, 0, 3, 64'h3000, 8'h0C, 1, 0);
    chk("sh.wd", last_wd[31:16], 16'hABCD);
    mem_op("lh", 7'h03, 3'b001, 64'h8006, 0, 64'h8001000000000000, 1,
           64'h8000, 8'hC0, 0, 64'hFFFFFFFFFFFF8001);
    mem_op("sw", 7'h23, 3'b010, 64'h9004, 64'h12345678, 0, 1, 64'h9000, 8'hF0, 1, 0);
    chk("sw.wd", last_wd[63:32], 32'h12345678);
    exc_op("lw_mis", 7'h03, 3'b010, 64'h4002, 4'd4);
    exc_op("sd_mis", 7'h23, 3'b011, 64'h5004, 4'd6);
    lsu_valid = 1; op_ir = {5'b0, 3'b000, 7'b0110011}; addr = 64'h100;
    tick();
    lsu_valid = 0;
    chk("rtype.req", dc_req, 0); chk("rtype.exc", lsu_exc, 0);
    tick();
    chk("rtype.done", lsu_done, 0);
    lsu_valid = 1; op_ir = {5'b0, 3'b010, 7'h03}; addr = 64'h7000; dc_rdata = 64'hDEADBEEF;
    tick();
    lsu_valid = 0;
    chk("rstreq.req1", dc_req, 1);
    tick();
    chk("rstreq.req2", dc_req, 1);
    rst = 1; dc_ack = 1;
    tick();
    rst = 0; dc_ack = 0;
    chk("rstreq.drop", dc_req, 0);
    for (int i = 0; i < 3; i++) begin
      nd += int'(lsu_done);
      tick();
    end
    chk("rstreq.nodone", nd, 0);
    mem_op("lwu", 7'h03, 3'b110, 64'h6004, 0, 64'hF000000000000000, 0,
           64'h6000, 8'hF0, 0, 64'hF0000000);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
